mc_controller_ws: RTL
=====================

# mc_controller_ws

Parametrised multicycle MIPS controller with memory wait states. It extends the base multicycle FSM with BNE, ANDI and ORI, a `mem_ready` handshake on every memory state, a wait timeout with bus-error reporting, and illegal-opcode detection. It sits between the instruction register and the multicycle datapath, and drives every datapath enable and mux select from a registered state plus `op`, `funct`, `zero` and `mem_ready`.

## Interface
- `WAIT_EN`, 1: 1 means memory states honour `mem_ready`; 0 means `mem_ready` is treated as constant 1.
- `TIMEOUT`, 15: maximum consecutive cycles with `mem_ready=0` in one memory state; 0 disables the timeout. Range 0..255.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low.
- `op` in 6: instruction opcode. `funct` in 6: R-type function field.
- `zero` in 1: ALU zero flag. `mem_ready` in 1: memory access completes this cycle.
- `pcen`, `memwrite`, `irwrite`, `regwrite` out 1: write enables.
- `alusrca`, `iord`, `memtoreg`, `regdst` out 1: mux selects.
- `zext` out 1: zero-extend the immediate for ANDI/ORI.
- `alusrcb`, `pcsrc` out 2: mux selects.
- `alucontrol` out 4: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
- `illegal`, `bus_err` out 1: registered one-cycle pulses.
- `state` out 4: current state, for debug.

## Operation
- Signals not listed for a state are 0. `alucontrol` is ADD unless stated otherwise.
- **Opcodes:** lw 100011, sw 101011, R 000000, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, j 000010.
- **R-type funct:** 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR. Any other funct gives ADD.
- **States and encodings:**
  - FETCH 0: `alusrcb`=01; `irwrite`=`pcen`=`mem_ready`. Goes to DECODE on ready, otherwise stays.
  - DECODE 1: `alusrcb`=11. Branches on `op`:
    - lw/sw → MEMADR 2
    - R → RTYPEEX 6
    - beq → BEQEX 8
    - bne → BNEEX 12
    - addi → ADDIEX 9
    - andi → ANDIEX 13
    - ori → ORIEX 14
    - j → JEX 11
    - any other opcode → FETCH, with `illegal` pulsed.
  - MEMADR 2: `alusrca`=1, `alusrcb`=10. lw → MEMRD 3; sw → MEMWR 5.
  - MEMRD 3: `iord`=1. Goes to MEMWB 4 on ready.
  - MEMWB 4: `regwrite`=1, `memtoreg`=1. → FETCH.
  - MEMWR 5: `iord`=1, `memwrite`=1. Goes to FETCH on ready.
  - RTYPEEX 6: `alusrca`=1, `alusrcb`=00, funct decode. → RTYPEWB 7.
  - RTYPEWB 7: `regdst`=1, `regwrite`=1. → FETCH.
  - BEQEX 8: `alusrca`=1, SUB, `pcsrc`=01, `pcen`=`zero`. → FETCH.
  - BNEEX 12: same as BEQEX but `pcen`=~`zero`. → FETCH.
  - ADDIEX 9: `alusrca`=1, `alusrcb`=10. → IMMWB 10.
  - ANDIEX 13 and ORIEX 14: as ADDIEX but AND/OR, `zext`=1. → IMMWB 10.
  - IMMWB 10: `regwrite`=1. → FETCH.
  - JEX 11: `pcsrc`=10, `pcen`=1. → FETCH.
  - Unused code 15 → FETCH.
- **Wait counter:**
  - 8-bit counter, active only in FETCH, MEMRD and MEMWR.
  - Increments each cycle with `mem_ready`=0. Clears on any state change or on `mem_ready`=1.
  - If the counter equals TIMEOUT-1 and `mem_ready`=0 (TIMEOUT≠0): next state is FETCH, `bus_err` pulses next cycle, counter clears.
  - `mem_ready`=1 in the same cycle as the limit: ready wins and there is no error.
  - `memwrite` stays high throughout a stalled MEMWR, including the timeout cycle.

## Timing
- **Reset:** on a rising edge with `reset`=0, `state`←FETCH and counter←0. `illegal`, `bus_err`←0.
- **While `reset`=0:** `pcen`, `irwrite`, `memwrite` and `regwrite` are forced 0. Selects take FETCH values: `alusrcb`=01, `alucontrol`=0010, all others 0.
- **Output timing:** Moore outputs decode from the registered state. `pcen` and `irwrite` are combinational in `zero`/`mem_ready`.
- **Cycles per instruction with zero waits:** lw 5, sw 4, R 4, addi/andi/ori 4, beq/bne 3, j 3, illegal 2.
- **Stalls:** each stalled cycle adds 1 in FETCH, MEMRD or MEMWR.
- **Pulses:** `illegal` and `bus_err` are high exactly one cycle, the cycle after the offending edge.
- **Reset mid-instruction:** aborts the instruction; the next instruction starts from FETCH. A pending pulse is suppressed.

## Test plan
- **Reset and lw:** reset low 1 edge, then lw with `mem_ready`=1. Expect states 0,1,2,3,4,0. `regwrite`=`memtoreg`=1 only in state 4.
- **bne:** `zero`=0 gives `pcen`=1 and `pcsrc`=01 in state 12. `zero`=1 gives `pcen`=0. Same for beq with `zero` inverted.
- **andi:** `alucontrol`=0000 and `zext`=1 in state 13, then `regwrite` in state 10.
- **R-type:** funct 101010 gives `alucontrol`=0111 in state 6 and `regdst`=1 in state 7. funct 100111 gives 1100.
- **Waits and timeout (TIMEOUT=4):**
  - MEMRD with `mem_ready` low 3 cycles then high: 3 extra cycles in state 3, no `bus_err`.
  - Low 4 cycles: return to FETCH, `bus_err` high 1 cycle.
  - `WAIT_EN`=0: `mem_ready` is ignored.
- **Illegal opcode and reset mid-op:**
  - op 111111: states 0,1,0 and `illegal` pulses once.
  - `reset` low during MEMWR: `memwrite`=0 that cycle and state 0 next.

Source files
------------

// File: rtl/mc_controller_ws.sv
// mc_controller_ws: multicycle MIPS controller with memory wait states, wait timeout and illegal-opcode detection
module mc_controller_ws #(
   parameter bit          WAIT_EN = 1'b1,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcen,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic       alusrca,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic       zext,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [3:0] alucontrol,
   output logic       illegal,
   output logic       bus_err,
   output logic [3:0] state
);
   typedef enum logic [3:0] {
      s_fetch   = 4'd0,
      s_decode  = 4'd1,
      s_memadr  = 4'd2,
      s_memrd   = 4'd3,
      s_memwb   = 4'd4,
      s_memwr   = 4'd5,
      s_rtypeex = 4'd6,
      s_rtypewb = 4'd7,
      s_beqex   = 4'd8,
      s_addiex  = 4'd9,
      s_immwb   = 4'd10,
      s_jex     = 4'd11,
      s_bneex   = 4'd12,
      s_andiex  = 4'd13,
      s_oriex   = 4'd14,
      s_unused  = 4'd15
   } state_t;

   localparam logic [5:0] op_lw = 6'b100011, op_sw = 6'b101011, op_r = 6'b000000;
   localparam logic [5:0] op_beq = 6'b000100, op_bne = 6'b000101, op_addi = 6'b001000;
   localparam logic [5:0] op_andi = 6'b001100, op_ori = 6'b001101, op_j = 6'b000010;
   localparam logic [3:0] alu_and = 4'b0000, alu_or = 4'b0001, alu_add = 4'b0010;
   localparam logic [3:0] alu_sub = 4'b0110, alu_slt = 4'b0111, alu_nor = 4'b1100;
   localparam logic [7:0] lim = 8'(TIMEOUT - 1);

   state_t     cur, nxt;
   logic [7:0] cnt;
   logic       rdy, mem_st, tmo, bad_op;

   assign rdy    = mem_ready | ~WAIT_EN;
   assign mem_st = cur inside {s_fetch, s_memrd, s_memwr};
   assign tmo    = mem_st && !rdy && (TIMEOUT != 0) && cnt == lim;
   assign state  = cur;

   always_comb begin
      nxt    = s_fetch;
      bad_op = 1'b0;
      case (cur)
         s_fetch:   nxt = rdy ? s_decode : s_fetch;
         s_decode: begin
            case (op)
               op_lw, op_sw: nxt = s_memadr;
               op_r:         nxt = s_rtypeex;
               op_beq:       nxt = s_beqex;
               op_bne:       nxt = s_bneex;
               op_addi:      nxt = s_addiex;
               op_andi:      nxt = s_andiex;
               op_ori:       nxt = s_oriex;
               op_j:         nxt = s_jex;
               default:      bad_op = 1'b1;
            endcase
         end
         s_memadr:  nxt = (op == op_sw) ? s_memwr : s_memrd;
         s_memrd:   nxt = rdy ? s_memwb : s_memrd;
         s_memwr:   nxt = rdy ? s_fetch : s_memwr;
         s_rtypeex: nxt = s_rtypewb;
         s_addiex, s_andiex, s_oriex: nxt = s_immwb;
         default:   nxt = s_fetch;
      endcase
      if (tmo) nxt = s_fetch;
   end

   // while reset is low every state decodes as an inert FETCH
   always_comb begin
      pcen       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      iord       = 1'b0;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      zext       = 1'b0;
      alusrcb    = reset ? 2'b00 : 2'b01;
      pcsrc      = 2'b00;
      alucontrol = alu_add;
      if (reset) begin
         case (cur)
            s_fetch: begin
               alusrcb = 2'b01;
               irwrite = rdy;
               pcen    = rdy;
            end
            s_decode: alusrcb = 2'b11;
            s_memadr: begin
               alusrca = 1'b1;
               alusrcb = 2'b10;
            end
            s_memrd: iord = 1'b1;
            s_memwb: begin
               regwrite = 1'b1;
               memtoreg = 1'b1;
            end
            s_memwr: begin
               iord     = 1'b1;
               memwrite = 1'b1;
            end
            s_rtypeex: begin
               alusrca    = 1'b1;
               alucontrol = funct == 6'b100010 ? alu_sub :
                            funct == 6'b100100 ? alu_and :
                            funct == 6'b100101 ? alu_or  :
                            funct == 6'b101010 ? alu_slt :
                            funct == 6'b100111 ? alu_nor : alu_add;
            end
            s_rtypewb: begin
               regdst   = 1'b1;
               regwrite = 1'b1;
            end
            s_beqex, s_bneex: begin
               alusrca    = 1'b1;
               alucontrol = alu_sub;
               pcsrc      = 2'b01;
               pcen       = (cur == s_beqex) ? zero : ~zero;
            end
            s_addiex, s_andiex, s_oriex: begin
               alusrca    = 1'b1;
               alusrcb    = 2'b10;
               zext       = cur != s_addiex;
               alucontrol = cur == s_andiex ? alu_and : cur == s_oriex ? alu_or : alu_add;
            end
            s_immwb: regwrite = 1'b1;
            s_jex: begin
               pcsrc = 2'b10;
               pcen  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cur     <= s_fetch;
         cnt     <= '0;
         illegal <= 1'b0;
         bus_err <= 1'b0;
      end else begin
         cur     <= nxt;
         cnt     <= (mem_st && !rdy && !tmo) ? cnt + 8'd1 : 8'd0;
         illegal <= bad_op;
         bus_err <= tmo;
      end
   end
endmodule
